// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART (8 data bits, no parity, 1 stop bit, LSB first).
// The RX and TX engines are independent. Bit timing is derived from the clock and baud
// parameters, so no external baud tick is needed. All outputs are registered.
module uart_transceiver #(
    parameter int baud_rate    = 9600,
    parameter int sys_clk_freq = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       recv_error
);

    // Cycles per bit and per half bit. BIT_CYCLES must be at least 4.
    localparam int BIT_CYCLES  = sys_clk_freq / baud_rate;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES);

    // The counters count down to zero, so they are loaded with (period - 1).
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Receive-side registers
    logic             rx_meta_r;
    logic             rxs_r;
    logic             rxs_prev_r;
    logic             rx_fall_s;
    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_idx_r;
    logic [7:0]       rx_shift_r;
    logic [7:0]       rx_byte_r;
    logic             received_r;
    logic             recv_error_r;
    logic             is_receiving_r;

    // Transmit-side registers
    tx_state_t        tx_state_r;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [2:0]       tx_idx_r;
    logic [7:0]       tx_data_r;
    logic             tx_r;
    logic             is_transmitting_r;

    // A start is recognised only on a real 1->0 transition. This stops a held-low
    // (break) line from re-triggering the receiver.
    assign rx_fall_s = rxs_prev_r & ~rxs_r;

    assign tx              = tx_r;
    assign received        = received_r;
    assign rx_byte         = rx_byte_r;
    assign is_receiving    = is_receiving_r;
    assign is_transmitting = is_transmitting_r;
    assign recv_error      = recv_error_r;

    // Two-flop synchronizer for the asynchronous rx pin, plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r  <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            rx_meta_r  <= rx;
            rxs_r      <= rx_meta_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // RX FSM: samples at mid-bit, shifts in LSB first, and checks the start and stop bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r     <= RX_IDLE;
            rx_cnt_r       <= CNT_ZERO;
            rx_idx_r       <= 3'd0;
            rx_shift_r     <= 8'h00;
            rx_byte_r      <= 8'h00;
            received_r     <= 1'b0;
            recv_error_r   <= 1'b0;
            is_receiving_r <= 1'b0;
        end else begin
            received_r   <= 1'b0;
            recv_error_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_fall_s) begin
                        rx_state_r     <= RX_START;
                        rx_cnt_r       <= HALF_LOAD;
                        is_receiving_r <= 1'b1;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r != CNT_ZERO) begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end else if (!rxs_r) begin
                        rx_state_r <= RX_DATA;
                        rx_cnt_r   <= BIT_LOAD;
                        rx_idx_r   <= 3'd0;
                    end else begin
                        // The line went high again before mid-bit: this was a glitch, not a start bit.
                        recv_error_r   <= 1'b1;
                        is_receiving_r <= 1'b0;
                        rx_state_r     <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r != CNT_ZERO) begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end else begin
                        rx_shift_r <= {rxs_r, rx_shift_r[7:1]};
                        rx_cnt_r   <= BIT_LOAD;
                        if (rx_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r != CNT_ZERO) begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end else begin
                        if (rxs_r) begin
                            rx_byte_r  <= rx_shift_r;
                            received_r <= 1'b1;
                        end else begin
                            // Framing error: keep the last good byte.
                            recv_error_r <= 1'b1;
                        end
                        is_receiving_r <= 1'b0;
                        rx_state_r     <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_r     <= RX_IDLE;
                    is_receiving_r <= 1'b0;
                end
            endcase
        end
    end

    // TX FSM: on an accepted strobe it drives the start bit, d0..d7, then the stop bit, each BIT_CYCLES long
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_r        <= TX_IDLE;
            tx_cnt_r          <= CNT_ZERO;
            tx_idx_r          <= 3'd0;
            tx_data_r         <= 8'h00;
            tx_r              <= 1'b1;
            is_transmitting_r <= 1'b0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (transmit) begin
                        tx_data_r         <= tx_byte;
                        tx_r              <= 1'b0;
                        is_transmitting_r <= 1'b1;
                        tx_cnt_r          <= BIT_LOAD;
                        tx_state_r        <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r != CNT_ZERO) begin
                        tx_cnt_r <= tx_cnt_r - CNT_ONE;
                    end else begin
                        tx_r       <= tx_data_r[0];
                        tx_idx_r   <= 3'd0;
                        tx_cnt_r   <= BIT_LOAD;
                        tx_state_r <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r != CNT_ZERO) begin
                        tx_cnt_r <= tx_cnt_r - CNT_ONE;
                    end else begin
                        tx_cnt_r <= BIT_LOAD;
                        if (tx_idx_r == 3'd7) begin
                            tx_r       <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_idx_r <= tx_idx_r + 3'd1;
                            tx_r     <= tx_data_r[tx_idx_r + 3'd1];
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r != CNT_ZERO) begin
                        tx_cnt_r <= tx_cnt_r - CNT_ONE;
                    end else begin
                        is_transmitting_r <= 1'b0;
                        tx_state_r        <= TX_IDLE;
                    end
                end
                default: begin
                    tx_r              <= 1'b1;
                    is_transmitting_r <= 1'b0;
                    tx_state_r        <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver (BIT_CYCLES = 16).
module tb_uart_transceiver;

    localparam int BITC  = 16;
    localparam int HALFC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx;
    logic       tx;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       is_transmitting;
    logic       recv_error;

    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;
    assign rx = loop_en ? tx : rx_drv;

    uart_transceiver #(.baud_rate(10000), .sys_clk_freq(160000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx),
        .transmit(transmit), .tx_byte(tx_byte),
        .received(received), .rx_byte(rx_byte),
        .is_receiving(is_receiving), .is_transmitting(is_transmitting),
        .recv_error(recv_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int recv_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int run = 0;
    int last_run = 0;
    int last_recv_cyc = 0;
    int start_cyc = 0;
    logic [7:0] rx_log [32];

    // Monitor: observes the pulse outputs and the length of each is_transmitting run, sampling at the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (received) begin
            rx_log[recv_cnt % 32] = rx_byte;
            recv_cnt = recv_cnt + 1;
            last_recv_cyc = cyc;
        end
        if (recv_error) err_cnt = err_cnt + 1;
        if (received && recv_error) both_cnt = both_cnt + 1;
        if (is_transmitting) begin
            run = run + 1;
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line levels in time order: start bit, data LSB first, stop bit.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Must be called at a negedge. Samples tx mid-bit and returns at negedge A+160.5.
    task automatic tx_frame(input logic [7:0] b, input int inj_at, input logic [7:0] ib,
                            output logic [9:0] bits);
        transmit = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        for (int c = 0; c < 10 * BITC; c++) begin
            if (inj_at != 0 && c == inj_at) begin
                transmit = 1'b1;
                tx_byte  = ib;
            end else begin
                transmit = 1'b0;
            end
            if (c % BITC == 7) bits[c / BITC] = tx;
            @(negedge clk);
        end
        transmit = 1'b0;
    endtask

    // Must be called at a negedge. Drives a frame with the given stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl, output logic mid_rx);
        rx_drv    = 1'b0;
        start_cyc = cyc;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BITC) @(negedge clk);
            if (i == 3) mid_rx = is_receiving;
        end
        rx_drv = stop_lvl;
        repeat (BITC) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] bits;
        logic       mid;
        int         rc0;
        int         ec0;
        int         fs_c;
        logic       seen;

        // Reset state
        #12;
        chk("reset_state", {19'd0, tx, received, recv_error, is_receiving, is_transmitting, rx_byte},
            32'h0000_1000);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // TX 0xA5
        tx_frame(8'hA5, 0, 8'h00, bits);
        chk("tx_a5_bits", {22'd0, bits}, {22'd0, frame_of(8'hA5)});
        chk("tx_a5_idle", {30'd0, tx, is_transmitting}, 32'd2);
        @(negedge clk);
        chk("tx_a5_busy_len", last_run, 32'd160);
        repeat (5) @(negedge clk);

        // RX 0x3C
        rc0 = recv_cnt;
        ec0 = err_cnt;
        send_frame(8'h3C, 1'b1, mid);
        repeat (20) @(negedge clk);
        chk("rx_3c_count", recv_cnt - rc0, 32'd1);
        chk("rx_3c_byte", {24'd0, rx_byte}, 32'h3C);
        chk("rx_3c_latency_ok",
            {31'd0, ((last_recv_cyc - start_cyc) >= 152) && ((last_recv_cyc - start_cyc) <= 158)},
            32'd1);
        chk("rx_3c_mid_receiving", {31'd0, mid}, 32'd1);
        chk("rx_3c_no_error", err_cnt - ec0, 32'd0);
        chk("rx_3c_idle_after", {31'd0, is_receiving}, 32'd0);

        // Framing error on 0x55
        rc0 = recv_cnt;
        ec0 = err_cnt;
        send_frame(8'h55, 1'b0, mid);
        repeat (20) @(negedge clk);
        chk("frame_err_count", err_cnt - ec0, 32'd1);
        chk("frame_err_no_recv", recv_cnt - rc0, 32'd0);
        chk("frame_err_byte_kept", {24'd0, rx_byte}, 32'h3C);

        // False start: a 4-cycle glitch
        rc0  = recv_cnt;
        ec0  = err_cnt;
        seen = 1'b0;
        fs_c = 40;
        rx_drv = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 4) rx_drv = 1'b1;
            if (is_receiving) seen = 1'b1;
            if (seen && !is_receiving) begin
                fs_c = c;
                break;
            end
        end
        chk("false_start_seen", {31'd0, seen}, 32'd1);
        chk("false_start_return_ok", {31'd0, fs_c <= HALFC + 3}, 32'd1);
        repeat (10) @(negedge clk);
        chk("false_start_err", err_cnt - ec0, 32'd1);
        chk("false_start_no_recv", recv_cnt - rc0, 32'd0);

        // Break: line held low yields one error, then normal reception resumes
        rc0 = recv_cnt;
        ec0 = err_cnt;
        rx_drv = 1'b0;
        repeat (400) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        chk("break_one_err", err_cnt - ec0, 32'd1);
        chk("break_no_recv", recv_cnt - rc0, 32'd0);
        send_frame(8'h81, 1'b1, mid);
        repeat (20) @(negedge clk);
        chk("after_break_byte", {24'd0, rx_byte}, 32'h81);

        // Busy ignore and back-to-back, with loopback
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        rc0 = recv_cnt;
        tx_frame(8'h12, 50, 8'hFF, bits);
        chk("busy_ignore_bits", {22'd0, bits}, {22'd0, frame_of(8'h12)});
        tx_frame(8'hFF, 0, 8'h00, bits);
        chk("b2b_ff_bits", {22'd0, bits}, {22'd0, frame_of(8'hFF)});
        repeat (20) @(negedge clk);
        chk("loop_count", recv_cnt - rc0, 32'd2);
        chk("loop_first", {24'd0, rx_log[rc0 % 32]}, 32'h12);
        chk("loop_second", {24'd0, rx_log[(rc0 + 1) % 32]}, 32'hFF);
        loop_en = 1'b0;
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of a TX frame
        transmit = 1'b1;
        tx_byte  = 8'h5A;
        @(negedge clk);
        transmit = 1'b0;
        repeat (70) @(negedge clk);
        chk("pre_reset_busy", {31'd0, is_transmitting}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_tx", {30'd0, tx, is_transmitting}, 32'd2);
        chk("async_reset_rx_byte", {24'd0, rx_byte}, 32'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tx_frame(8'h00, 0, 8'h00, bits);
        chk("post_reset_00_bits", {22'd0, bits}, {22'd0, frame_of(8'h00)});
        chk("post_reset_idle", {30'd0, tx, is_transmitting}, 32'd2);

        chk("never_both_pulses", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART: 8 data bits, no parity, 1 stop bit, LSB first.
- Independent RX and TX engines with a single-cycle strobe handshake.
- Sits beneath the comm-layer packet FSM, which pushes bytes via transmit/tx_byte and consumes bytes via received/rx_byte.
- Bit timing is derived from parameters; no external baud tick.

Parameters:
- baud_rate, 9600: line rate in bits/s.
- sys_clk_freq, 12000000: clk frequency in Hz.
- Derived BIT_CYCLES = sys_clk_freq / baud_rate, integer-truncated (1250 at defaults); must be ≥ 4.
- Derived HALF_CYCLES = BIT_CYCLES / 2, integer-truncated.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, asynchronous to clk, idle high.
- tx  out  1  serial output, idle high.
- transmit  in  1  one-cycle strobe: start sending tx_byte.
- tx_byte  in  8  byte to send; sampled only on an accepted strobe.
- received  out  1  one-cycle pulse: rx_byte holds a valid new byte.
- rx_byte  out  8  last correctly received byte.
- is_receiving  out  1  high while an RX frame is in progress.
- is_transmitting  out  1  high while a TX frame is in progress.
- recv_error  out  1  one-cycle pulse on a false start or framing error.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, rx_byte=0, received=0, recv_error=0, is_receiving=0, is_transmitting=0; both FSMs go to IDLE; counters clear.
- Reset mid-frame aborts the frame immediately; tx returns to 1.
- rx passes through a 2-flop synchronizer (reset value 1). All RX timing below refers to the synchronized signal rxs.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a 1→0 transition on rxs → START; is_receiving=1; counter loads HALF_CYCLES.
  - START: at counter expiry, sample rxs.
    - rxs=0: → DATA; counter = BIT_CYCLES.
    - rxs=1: false start; pulse recv_error; → IDLE.
  - DATA: sample rxs every BIT_CYCLES; shift in LSB first; after 8 samples → STOP.
  - STOP: one BIT_CYCLES later, sample rxs.
    - rxs=1: rx_byte ← shift register and received pulses in the same cycle.
    - rxs=0: pulse recv_error only; rx_byte is unchanged.
    - Either way → IDLE, is_receiving=0.
- RX may re-arm on the very next falling edge after STOP, giving back-to-back frames at full rate.
- received and recv_error are never high in the same cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - In IDLE, transmit=1 is accepted: tx_byte is latched, and on that same edge is_transmitting=1 and tx=0 (start bit).
  - Each bit lasts exactly BIT_CYCLES cycles: start bit, d0..d7, then stop bit (1). After the stop bit → IDLE, is_transmitting=0.
  - transmit while is_transmitting=1 is ignored. There is no queue, and the latched byte is not modified.
  - Total frame duration = 10·BIT_CYCLES cycles.
- RX and TX operate fully independently; simultaneous activity is allowed, and loopback (tx→rx) must work.
- tx is registered (glitch-free).
- A held-low rx line (break) yields at most one recv_error and no received pulse. The next frame starts only after rxs returns high and falls again.

Test Plan (sim params sys_clk_freq=160000, baud_rate=10000 → BIT_CYCLES=16):
- TX 0xA5: pulse transmit=1 with tx_byte=0xA5 → tx levels, 16 cycles each: 0,1,0,1,0,0,1,0,1,1. is_transmitting is high for exactly 160 cycles, then tx=1.
- RX 0x3C: drive a frame with 16-cycle bits → one received pulse with rx_byte=0x3C, ~154 cycles after the falling edge (2 sync + 8 + 9·16). is_receiving spans the frame; recv_error stays 0.
- Framing error: send 0x55 with the stop bit held 0 → recv_error pulses once, no received pulse, rx_byte keeps its previous value (0x3C).
- False start: a 4-cycle low glitch on rx → recv_error pulse, no received, is_receiving returns to 0 within HALF_CYCLES+3 cycles.
- Busy ignore / back-to-back: transmit 0x12, then transmit 0xFF at cycle 50 → only 0x12 appears on tx. A second transmit right after is_transmitting falls sends 0xFF. Loopback tx→rx yields received bytes 0x12 then 0xFF.
- Async reset: assert rst=0 mid-TX frame at cycle 70 → tx=1 and is_transmitting=0 immediately, without waiting for a clock edge. After release, the next transmit of 0x00 produces a correct frame.
